cmp_pipe: RTL and testbench

Parametrised, pipelined compare/test unit that generalises the combinational CMP flag generator to any `WIDTH`. It executes four flag-setting operations (CMP, CMN, TST, TEQ) behind a valid/ready handshake and owns the architectural `[N,Z,C,V]` flag register. Each operation can be predicated on a condition code evaluated against that register. It sits in the ALU between operand issue and writeback and replaces direct use of CMP.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/cond_eval.sv | 39 +++
 rtl/cmp_pipe.sv | 164 ++++++++++++++++
 tb/tb_cmp_pipe.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU encodings: operation modes, condition codes and flag bit positions.
package alu_pkg;

  localparam logic [1:0] MODE_CMP = 2'b00;
  localparam logic [1:0] MODE_CMN = 2'b01;
  localparam logic [1:0] MODE_TST = 2'b10;
  localparam logic [1:0] MODE_TEQ = 2'b11;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code check of a 4-bit cond against the [N,Z,C,V] flags.
module cond_eval
  import alu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b1;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/cmp_pipe.sv
// Two-stage CMP/CMN/TST/TEQ unit owning the [N,Z,C,V] flag register.
// Predication is built only when CMP_PIPE_COND_EN is defined.
module cmp_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  input  logic             in_s,
  input  logic [3:0]       in_cond,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             out_exec,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       flags,
  input  logic             flag_load,
  input  logic [3:0]       flag_din
);

  logic                    s1_valid_q, s1_valid_d;
  logic signed [WIDTH-1:0] a_q, b_q;
  logic [1:0]              mode_q;
  logic                    s_q;
  logic [TAG_W-1:0]        tag_q;

  logic                    out_valid_q, out_valid_d;
  logic [WIDTH-1:0]        out_result_q;
  logic [3:0]              out_flags_q;
  logic [TAG_W-1:0]        out_tag_q;
  logic [3:0]              flags_q, flags_d;

  logic                    adv2, accept, exec;
  logic [WIDTH:0]          res_w;
  logic [WIDTH-1:0]        res;
  logic [3:0]              fl_c;

  assign adv2     = s1_valid_q & (~out_valid_q | out_ready);
  assign in_ready = ~s1_valid_q | adv2;
  assign accept   = in_valid & in_ready;

`ifdef CMP_PIPE_COND_EN
  logic [3:0] cond_q;
  logic       out_exec_q;

  always_ff @(posedge clk) begin
    if (accept) cond_q <= in_cond;
  end

  // Condition sees the flags as they stand before this op commits.
  cond_eval u_cond_eval (
    .cond  (cond_q),
    .flags (flags_q),
    .pass  (exec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)    out_exec_q <= 1'b0;
    else if (adv2) out_exec_q <= exec;
  end

  assign out_exec = out_exec_q;
`else
  logic unused_cond;

  assign unused_cond = ^in_cond;
  assign exec        = 1'b1;
  assign out_exec    = 1'b1;
`endif

  // Stage 1: capture the offered op.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q    <= in_a;
      b_q    <= in_b;
      mode_q <= in_mode;
      s_q    <= in_s;
      tag_q  <= in_tag;
    end
  end

  // Extra top bit of res_w is the carry (CMN) or borrow (CMP).
  always_comb begin
    res_w = '0;
    case (mode_q)
      MODE_CMP: res_w = {1'b0, a_q} - {1'b0, b_q};
      MODE_CMN: res_w = {1'b0, a_q} + {1'b0, b_q};
      MODE_TST: res_w = {1'b0, a_q & b_q};
      MODE_TEQ: res_w = {1'b0, a_q ^ b_q};
      default:  res_w = '0;
    endcase
    res = res_w[WIDTH-1:0];

    fl_c         = '0;
    fl_c[FLAG_N] = res[WIDTH-1];
    fl_c[FLAG_Z] = ~|res;
    case (mode_q)
      MODE_CMP: begin
        fl_c[FLAG_C] = ~res_w[WIDTH];
        fl_c[FLAG_V] = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (res[WIDTH-1] ^ a_q[WIDTH-1]);
      end
      MODE_CMN: begin
        fl_c[FLAG_C] = res_w[WIDTH];
        fl_c[FLAG_V] = ~(a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (res[WIDTH-1] ^ a_q[WIDTH-1]);
      end
      default: begin
        fl_c[FLAG_C] = flags_q[FLAG_C];
        fl_c[FLAG_V] = flags_q[FLAG_V];
      end
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (adv2)   s1_valid_d = 1'b0;
    if (accept) s1_valid_d = 1'b1;

    out_valid_d = out_valid_q;
    if (out_ready) out_valid_d = 1'b0;
    if (adv2)      out_valid_d = 1'b1;

    // An explicit load wins over a same-cycle commit.
    flags_d = flags_q;
    if (adv2 & exec & s_q) flags_d = fl_c;
    if (flag_load)         flags_d = flag_din;
  end

  // Stage 2: register the evaluated op.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
      out_tag_q    <= '0;
      flags_q      <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      flags_q     <= flags_d;
      if (adv2) begin
        out_result_q <= res;
        out_flags_q  <= fl_c;
        out_tag_q    <= tag_q;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;
  assign out_tag    = out_tag_q;
  assign flags      = flags_q;

endmodule

// File: tb/tb_cmp_pipe.sv
// Bench for cmp_pipe at WIDTH=32 and WIDTH=8: vector tables, a queue scoreboard and handshake corner cases.
module tb_cmp_pipe;

`ifdef CMP_PIPE_COND_EN
  localparam bit COND_EN = 1'b1;
`else
  localparam bit COND_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] a, b;
    logic [1:0]  mode;
    logic        s;
    logic [31:0] res;
    logic [3:0]  fl;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  fl;
    logic        ex;
    logic [3:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance signals
  logic        iv32 = 0, ir32, s32 = 0, or32 = 1, ov32, oex32, fld32 = 0;
  logic [31:0] a32 = 0, b32 = 0, ores32;
  logic [1:0]  m32 = 0;
  logic [3:0]  c32 = 4'd14, t32 = 0, ofl32, ot32, fl32, fdin32 = 0;
  // 8-bit instance signals
  logic        iv8 = 0, ir8, s8 = 0, or8 = 1, ov8, oex8, fld8 = 0;
  logic [7:0]  a8 = 0, b8 = 0, ores8;
  logic [1:0]  m8 = 0;
  logic [3:0]  c8 = 4'd14, t8 = 0, ofl8, ot8, fl8, fdin8 = 0;

  cmp_pipe #(.WIDTH(32), .TAG_W(4)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .in_a(a32), .in_b(b32),
    .in_mode(m32), .in_s(s32), .in_cond(c32), .in_tag(t32), .out_valid(ov32), .out_ready(or32),
    .out_result(ores32), .out_flags(ofl32), .out_exec(oex32), .out_tag(ot32), .flags(fl32),
    .flag_load(fld32), .flag_din(fdin32));

  cmp_pipe #(.WIDTH(8), .TAG_W(4)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8),
    .in_mode(m8), .in_s(s8), .in_cond(c8), .in_tag(t8), .out_valid(ov8), .out_ready(or8),
    .out_result(ores8), .out_flags(ofl8), .out_exec(oex8), .out_tag(ot8), .flags(fl8),
    .flag_load(fld8), .flag_din(fdin8));

  int n_vec = 0, n_fail = 0;
  int pops32 = 0, stall32 = 0;
  exp_t q32[$], q8[$];
  logic [3:0] mf32 = 0, mf8 = 0;
  logic acc32, acc8;
  logic ovr_en = 0;
  logic [31:0] ovr_res;
  logic [3:0] ovr_fl;

  function automatic logic cpass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'd0: return z;        4'd1: return !z;
      4'd2: return c;        4'd3: return !c;
      4'd4: return n;        4'd5: return !n;
      4'd6: return v;        4'd7: return !v;
      4'd8: return c && !z;  4'd9: return !c || z;
      4'd10: return n == v;  4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic void model(input int w, input logic [31:0] a, b, input logic [1:0] mode,
                                input logic [3:0] cond, input logic [3:0] fin,
                                output logic [31:0] r, output logic [3:0] fl, output logic ex);
    logic [31:0] mask, am, bm;
    logic [32:0] sum;
    logic c, v;
    int msb;
    msb  = w - 1;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    am   = a & mask;
    bm   = b & mask;
    c    = fin[1];
    v    = fin[0];
    case (mode)
      2'b00: begin
        r = (am - bm) & mask;
        c = (am >= bm);
        v = (am[msb] != bm[msb]) && (r[msb] != am[msb]);
      end
      2'b01: begin
        r   = (am + bm) & mask;
        sum = {1'b0, am} + {1'b0, bm};
        c   = (sum > {1'b0, mask});
        v   = (am[msb] == bm[msb]) && (r[msb] != am[msb]);
      end
      2'b10: r = am & bm;
      default: r = am ^ bm;
    endcase
    fl = {r[msb], (r == 32'd0), c, v};
    ex = COND_EN ? cpass(cond, fin) : 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: sample both handshakes at negedge+1, update scoreboard, cross the edge.
  task automatic step();
    exp_t e;
    logic [31:0] r;
    logic [3:0] f;
    logic x;
    or32 = (stall32 > 0) ? 1'b0 : 1'b1;
    if (stall32 > 0) stall32--;
    #1;
    if (rst_n && ov32 && or32) begin
      n_vec++;
      if (q32.size() == 0) begin
        n_fail++;
        $display("FAIL sb32: unexpected output tag=%0d", ot32);
      end else begin
        e = q32.pop_front();
        pops32++;
        if ({ores32, ofl32, oex32, ot32} !== {e.res, e.fl, e.ex, e.tag}) begin
          n_fail++;
          $display("FAIL sb32: got res=%h fl=%b ex=%b tag=%0d, expected res=%h fl=%b ex=%b tag=%0d",
                   ores32, ofl32, oex32, ot32, e.res, e.fl, e.ex, e.tag);
        end
      end
    end
    if (rst_n && ov8 && or8) begin
      n_vec++;
      if (q8.size() == 0) begin
        n_fail++;
        $display("FAIL sb8: unexpected output tag=%0d", ot8);
      end else begin
        e = q8.pop_front();
        if ({ores8, ofl8, oex8, ot8} !== {e.res[7:0], e.fl, e.ex, e.tag}) begin
          n_fail++;
          $display("FAIL sb8: got res=%h fl=%b ex=%b tag=%0d, expected res=%h fl=%b ex=%b tag=%0d",
                   ores8, ofl8, oex8, ot8, e.res[7:0], e.fl, e.ex, e.tag);
        end
      end
    end
    acc32 = rst_n && iv32 && ir32;
    if (acc32) begin
      model(32, a32, b32, m32, c32, mf32, r, f, x);
      if (x && s32) mf32 = f;
      e.res = ovr_en ? ovr_res : r;
      e.fl  = ovr_en ? ovr_fl : f;
      e.ex  = x;
      e.tag = t32;
      q32.push_back(e);
    end
    if (rst_n && fld32) mf32 = fdin32;
    acc8 = rst_n && iv8 && ir8;
    if (acc8) begin
      model(8, {24'd0, a8}, {24'd0, b8}, m8, c8, mf8, r, f, x);
      if (x && s8) mf8 = f;
      e.res = ovr_en ? ovr_res : r;
      e.fl  = ovr_en ? ovr_fl : f;
      e.ex  = x;
      e.tag = t8;
      q8.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send32(input logic [31:0] a, b, input logic [1:0] m, input logic s,
                        input logic [3:0] cond, input logic [3:0] tag, output int rejects);
    rejects = 0;
    a32 = a; b32 = b; m32 = m; s32 = s; c32 = cond; t32 = tag; iv32 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (acc32) break;
      rejects++;
    end
    if (!acc32) chk("send32_timeout", 32'd0, 32'd1);
    iv32 = 1'b0;
  endtask

  task automatic send8(input logic [7:0] a, b, input logic [1:0] m, input logic s, input logic [3:0] tag);
    a8 = a; b8 = b; m8 = m; s8 = s; c8 = 4'd14; t8 = tag; iv8 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (acc8) break;
    end
    if (!acc8) chk("send8_timeout", 32'd0, 32'd1);
    iv8 = 1'b0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 40; i++) begin
      if (q32.size() == 0 && q8.size() == 0 && !ov32 && !ov8) break;
      step();
    end
    if (i == 40) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  vec_t tv32[13];
  vec_t tv8[5];

  initial begin
    int rj, rj_total, p0;
    logic [3:0] fexp;

    tv32[0]  = '{32'd2,          32'd3,          2'b00, 1'b1, 32'hFFFF_FFFF, 4'b1000};
    tv32[1]  = '{32'd10,         32'd10,         2'b00, 1'b1, 32'h0,         4'b0110};
    tv32[2]  = '{32'hFFFF_FFFF,  32'd9,          2'b00, 1'b1, 32'hFFFF_FFF6, 4'b1010};
    tv32[3]  = '{32'h7FFF_FFFF,  32'hFFFF_FFFF,  2'b00, 1'b1, 32'h8000_0000, 4'b1001};
    tv32[4]  = '{32'd4,          32'hFFFF_FFFC,  2'b01, 1'b1, 32'h0,         4'b0110};
    tv32[5]  = '{32'h8000_0000,  32'd1,          2'b00, 1'b1, 32'h7FFF_FFFF, 4'b0011};
    tv32[6]  = '{32'hF0,         32'h0F,         2'b10, 1'b1, 32'h0,         4'b0111};
    tv32[7]  = '{32'd5,          32'd5,          2'b11, 1'b1, 32'h0,         4'b0111};
    tv32[8]  = '{32'h8000_0000,  32'd0,          2'b11, 1'b1, 32'h8000_0000, 4'b1011};
    tv32[9]  = '{32'd1,          32'd1,          2'b00, 1'b0, 32'h0,         4'b0110};
    tv32[10] = '{32'd0,          32'd0,          2'b10, 1'b1, 32'h0,         4'b0111};
    tv32[11] = '{32'h7FFF_FFFF,  32'd1,          2'b01, 1'b1, 32'h8000_0000, 4'b1001};
    tv32[12] = '{32'hFFFF_FFFF,  32'd1,          2'b01, 1'b1, 32'h0,         4'b0110};

    tv8[0] = '{32'h02, 32'h03, 2'b00, 1'b1, 32'hFF, 4'b1000};
    tv8[1] = '{32'h0A, 32'h0A, 2'b00, 1'b1, 32'h00, 4'b0110};
    tv8[2] = '{32'hFF, 32'h09, 2'b00, 1'b1, 32'hF6, 4'b1010};
    tv8[3] = '{32'h7F, 32'hFF, 2'b00, 1'b1, 32'h80, 4'b1001};
    tv8[4] = '{32'h04, 32'hFC, 2'b01, 1'b1, 32'h00, 4'b0110};

    @(negedge clk);
    rst_n = 1'b0;
    step();
    step();
    chk("rst_out_valid", {31'd0, ov32}, 32'd0);
    chk("rst_flags", {28'd0, fl32}, 32'd0);
    chk("rst_out_result", ores32, 32'd0);
    chk("rst_out_flags_tag", {24'd0, ofl32, ot32}, 32'd0);
    chk("rst_out_exec", {31'd0, oex32}, {31'd0, !COND_EN});
    chk("rst8_state", {24'd0, ov8, fl8, ores8[2:0]}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, ir32}, 32'd1);
    #1;

    // Vector table, 32-bit
    fexp = 4'b0000;
    ovr_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      ovr_res = tv32[i].res;
      ovr_fl  = tv32[i].fl;
      if (tv32[i].s) fexp = tv32[i].fl;
      send32(tv32[i].a, tv32[i].b, tv32[i].mode, tv32[i].s, 4'd14, 4'(i), rj);
    end
    ovr_en = 1'b0;
    drain();
    chk("table32_flags", {28'd0, fl32}, {28'd0, fexp});

    // Predication pairs, back to back
    send32(32'd10, 32'd10, 2'b00, 1'b1, 4'd14, 4'd1, rj);
    send32(32'd1,  32'd2,  2'b00, 1'b1, 4'd1,  4'd2, rj);
    drain();
    chk("pred_ne_flags", {28'd0, fl32}, COND_EN ? 32'b0110 : 32'b1000);
    send32(32'd10, 32'd10, 2'b00, 1'b1, 4'd14, 4'd3, rj);
    send32(32'd1,  32'd2,  2'b00, 1'b1, 4'd0,  4'd4, rj);
    drain();
    chk("pred_eq_flags", {28'd0, fl32}, 32'b1000);
    send32(32'd5,  32'd3,  2'b00, 1'b1, 4'd12, 4'd5, rj);
    send32(32'd3,  32'd5,  2'b00, 1'b1, 4'd8,  4'd6, rj);
    drain();
    chk("pred_model_flags", {28'd0, fl32}, {28'd0, mf32});

    // Back-pressure: output stalled for 3 cycles while 5 ops stream in
    p0 = pops32;
    rj_total = 0;
    stall32 = 3;
    for (int i = 0; i < 5; i++) begin
      send32(32'(i * 7), 32'd3, 2'(i), 1'b1, 4'd14, 4'(8 + i), rj);
      rj_total += rj;
    end
    drain();
    chk("bp_rejects", rj_total, 32'd1);
    chk("bp_pops", pops32 - p0, 32'd5);

    // Flag load collides with an S2 commit
    send32(32'd2, 32'd3, 2'b00, 1'b1, 4'd14, 4'd7, rj);
    fld32 = 1'b1;
    fdin32 = 4'b0101;
    step();
    fld32 = 1'b0;
    drain();
    chk("flag_load_prio", {28'd0, fl32}, 32'b0101);

    // Reset with two ops in flight
    stall32 = 100;
    send32(32'd2, 32'd3, 2'b00, 1'b1, 4'd14, 4'd1, rj);
    send32(32'd4, 32'd3, 2'b00, 1'b1, 4'd14, 4'd2, rj);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    stall32 = 0;
    or32 = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, ov32}, 32'd0);
    chk("midrst_flags", {28'd0, fl32}, 32'd0);
    chk("midrst_in_ready", {31'd0, ir32}, 32'd1);
    #1;
    q32.delete();
    mf32 = 4'b0000;
    mf8 = 4'b0000;
    send32(32'd9, 32'd9, 2'b00, 1'b1, 4'd14, 4'd3, rj);
    drain();

    // Vector table, 8-bit
    fexp = 4'b0000;
    ovr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ovr_res = tv8[i].res;
      ovr_fl  = tv8[i].fl;
      if (tv8[i].s) fexp = tv8[i].fl;
      send8(tv8[i].a[7:0], tv8[i].b[7:0], tv8[i].mode, tv8[i].s, 4'(i));
    end
    ovr_en = 1'b0;
    drain();
    chk("table8_flags", {28'd0, fl8}, {28'd0, fexp});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
